// File: rtl/sprite_plot_arbiter_pkg.sv
// Shared definitions for the sprite/animation blocks: default geometry, requester
// indices and the plot sequencer state encoding.
package sprite_plot_arbiter_pkg;

    localparam int unsigned DefSprW = 10;
    localparam int unsigned DefSprH = 11;
    localparam int unsigned DefScrW = 160;
    localparam int unsigned DefScrH = 120;

    localparam int unsigned ReqPlayer = 0;
    localparam int unsigned ReqEnemy  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StErase,
        StDraw,
        StDone
    } plot_state_e;

endpackage

// File: rtl/sprite_plot_arbiter_scan.sv
// Sprite pixel scanner: walks col 0..SPR_W-1 inside row 0..SPR_H-1 from a base corner
// and flags pixels that fall off the visible screen.
module sprite_scan
    import sprite_plot_arbiter_pkg::*;
#(
    parameter int unsigned SPR_W = DefSprW,
    parameter int unsigned SPR_H = DefSprH,
    parameter int unsigned SCR_W = DefScrW,
    parameter int unsigned SCR_H = DefScrH
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] base_x_i,
    input  logic [6:0] base_y_i,
    output logic       run_o,
    output logic       last_o,
    output logic       on_screen_o,
    output logic [7:0] x_o,
    output logic [6:0] y_o
);
    localparam int unsigned ColW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RowW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            run_q, run_d;
    logic [8:0]      x_full;
    logic [7:0]      y_full;

    // Wider sums so off-screen pixels clip instead of wrapping.
    assign x_full      = {1'b0, base_x_i} + 9'(col_q);
    assign y_full      = {1'b0, base_y_i} + 8'(row_q);
    assign on_screen_o = (x_full < 9'(SCR_W)) && (y_full < 8'(SCR_H));
    assign x_o         = x_full[7:0];
    assign y_o         = y_full[6:0];
    assign run_o       = run_q;
    assign last_o      = run_q && (col_q == ColW'(SPR_W - 1)) && (row_q == RowW'(SPR_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        run_d = run_q;
        if (start_i) begin
            col_d = '0;
            row_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (last_o) begin
                run_d = 1'b0;
            end else if (col_q == ColW'(SPR_W - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
            run_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// Round-robin arbiter that erases a requester's sprite at its old position and redraws
// it at the new one, emitting one registered VGA pixel write per cycle.
module sprite_plot_arbiter
    import sprite_plot_arbiter_pkg::*;
#(
    parameter int unsigned SPR_W = DefSprW,
    parameter int unsigned SPR_H = DefSprH,
    parameter int unsigned SCR_W = DefScrW,
    parameter int unsigned SCR_H = DefScrH
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    input  logic [15:0] old_x_i,
    input  logic [13:0] old_y_i,
    input  logic [15:0] new_x_i,
    input  logic [13:0] new_y_i,
    input  logic [5:0]  colour_i,
    input  logic [2:0]  bg_colour_i,
    output logic [1:0]  grant_o,
    output logic [1:0]  done_o,
    output logic        busy_o,
    output logic        plot_o,
    output logic [7:0]  vga_x_o,
    output logic [6:0]  vga_y_o,
    output logic [2:0]  vga_colour_o
);
    plot_state_e state_q, state_d;
    logic [1:0]  grant_q, grant_d, done_q, done_d;
    logic        busy_q, busy_d, plot_q, plot_d;
    logic [7:0]  vga_x_q, vga_x_d, old_x_q, old_x_d, new_x_q, new_x_d;
    logic [6:0]  vga_y_q, vga_y_d, old_y_q, old_y_d, new_y_q, new_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d, colour_q, colour_d;
    logic        rr_last_q, rr_last_d;  // index of the requester granted last
    logic        draw_q, draw_d;        // scanner is walking the new position

    logic       req_any, win;
    logic       scan_start, scan_run, scan_last, scan_on;
    logic [7:0] scan_x;
    logic [6:0] scan_y;

    assign req_any = |req_i;
    assign win     = req_i[ReqEnemy] & (~req_i[ReqPlayer] | ~rr_last_q);

    sprite_scan #(
        .SPR_W(SPR_W),
        .SPR_H(SPR_H),
        .SCR_W(SCR_W),
        .SCR_H(SCR_H)
    ) u_scan (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (scan_start),
        .base_x_i   (draw_q ? new_x_q : old_x_q),
        .base_y_i   (draw_q ? new_y_q : old_y_q),
        .run_o      (scan_run),
        .last_o     (scan_last),
        .on_screen_o(scan_on),
        .x_o        (scan_x),
        .y_o        (scan_y)
    );

    // The scanner runs one cycle ahead of the registered outputs, so state_q tracks
    // what is currently visible on the pins.
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        done_d     = '0;
        scan_start = 1'b0;
        draw_d     = draw_q;
        rr_last_d  = rr_last_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        colour_d   = colour_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d      = StErase;
                    scan_start   = 1'b1;
                    draw_d       = 1'b0;
                    rr_last_d    = win;
                    grant_d[win] = 1'b1;
                    old_x_d      = win ? old_x_i[15:8] : old_x_i[7:0];
                    old_y_d      = win ? old_y_i[13:7] : old_y_i[6:0];
                    new_x_d      = win ? new_x_i[15:8] : new_x_i[7:0];
                    new_y_d      = win ? new_y_i[13:7] : new_y_i[6:0];
                    colour_d     = win ? colour_i[5:3] : colour_i[2:0];
                end
            end
            StErase: begin
                grant_d = grant_q;
                if (scan_last && !draw_q) begin
                    scan_start = 1'b1;
                    draw_d     = 1'b1;
                end
                if (draw_q) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (scan_run) begin
                    grant_d = grant_q;
                end else begin
                    state_d = StDone;
                    done_d  = grant_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
        busy_d       = (state_d == StErase) || (state_d == StDraw);
        plot_d       = scan_run && scan_on;
        vga_x_d      = plot_d ? scan_x : '0;
        vga_y_d      = plot_d ? scan_y : '0;
        vga_colour_d = plot_d ? (draw_q ? colour_q : bg_colour_i) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            rr_last_q    <= 1'b1;
            draw_q       <= 1'b0;
            old_x_q      <= '0;
            old_y_q      <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            rr_last_q    <= rr_last_d;
            draw_q       <= draw_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            colour_q     <= colour_d;
        end
    end

    assign grant_o      = grant_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign plot_o       = plot_q;
    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_colour_o = vga_colour_q;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Self-checking bench: table of directed operations, random operations, and a reset
// mid-draw sequence, all compared against a per-cycle expected output trace.
module tb_sprite_plot_arbiter;
    localparam int SprW = 10;
    localparam int SprH = 11;
    localparam int ScrW = 160;
    localparam int ScrH = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] old_x, new_x;
    logic [13:0] old_y, new_y;
    logic [5:0]  colour;
    logic [2:0]  bg;
    logic [1:0]  grant, done;
    logic        busy, plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int checks = 0;
    int errors = 0;
    int model_last;

    typedef struct {
        logic [1:0] req;
        int         ox, oy, nx, ny;
        logic [2:0] col, bg;
        int         drop_at, chg_at;
        logic [1:0] exp_grant;
        int         exp_draw;
    } vec_t;

    vec_t vecs[7];

    sprite_plot_arbiter #(
        .SPR_W(SprW),
        .SPR_H(SprH),
        .SCR_W(ScrW),
        .SCR_H(ScrH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .req_i       (req),
        .old_x_i     (old_x),
        .old_y_i     (old_y),
        .new_x_i     (new_x),
        .new_y_i     (new_y),
        .colour_i    (colour),
        .bg_colour_i (bg),
        .grant_o     (grant),
        .done_o      (done),
        .busy_o      (busy),
        .plot_o      (plot),
        .vga_x_o     (vga_x),
        .vga_y_o     (vga_y),
        .vga_colour_o(vga_colour)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] pack(input logic [1:0] g, input logic [1:0] d,
                                         input logic b, input logic p, input logic [7:0] x,
                                         input logic [6:0] y, input logic [2:0] c);
        return {g, d, b, p, x, y, c};
    endfunction

    function automatic logic [23:0] actual();
        return pack(grant, done, busy, plot, vga_x, vga_y, vga_colour);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drives one operation starting in the current cycle (N) and checks N+1..N+223.
    task automatic do_op(input string tag, input logic [1:0] r, input int ox, input int oy,
                         input int nx, input int ny, input logic [2:0] col,
                         input logic [2:0] b, input int drop_at, input int chg_at,
                         input logic [1:0] exp_grant, input int exp_draw);
        int          w;
        int          drawn;
        logic [1:0]  g;
        logic [23:0] exp_q[$];
        w = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : ((model_last == 1) ? 0 : 1);
        model_last = w;
        g = (w == 0) ? 2'b01 : 2'b10;

        req    = r;
        bg     = b;
        old_x  = 16'($urandom);
        old_y  = 14'($urandom);
        new_x  = 16'($urandom);
        new_y  = 14'($urandom);
        colour = 6'($urandom);
        if (w == 0) begin
            old_x[7:0] = 8'(ox);  old_y[6:0] = 7'(oy);
            new_x[7:0] = 8'(nx);  new_y[6:0] = 7'(ny);
            colour[2:0] = col;
        end else begin
            old_x[15:8] = 8'(ox); old_y[13:7] = 7'(oy);
            new_x[15:8] = 8'(nx); new_y[13:7] = 7'(ny);
            colour[5:3] = col;
        end

        exp_q.push_back(pack(g, 2'b00, 1'b1, 1'b0, 8'd0, 7'd0, 3'd0));
        for (int ph = 0; ph < 2; ph++) begin
            for (int rr = 0; rr < SprH; rr++) begin
                for (int cc = 0; cc < SprW; cc++) begin
                    int x;
                    int y;
                    x = ((ph == 1) ? nx : ox) + cc;
                    y = ((ph == 1) ? ny : oy) + rr;
                    if (x < ScrW && y < ScrH)
                        exp_q.push_back(pack(g, 2'b00, 1'b1, 1'b1, 8'(x), 7'(y),
                                             (ph == 1) ? col : b));
                    else
                        exp_q.push_back(pack(g, 2'b00, 1'b1, 1'b0, 8'd0, 7'd0, 3'd0));
                end
            end
        end
        exp_q.push_back(pack(2'b00, g, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
        exp_q.push_back(24'd0);

        drawn = 0;
        for (int k = 1; k <= 223; k++) begin
            @(posedge clk);
            #1;
            if (k == drop_at) req = 2'b00;
            if (k == chg_at) begin
                old_x  = 16'($urandom);
                old_y  = 14'($urandom);
                new_x  = 16'($urandom);
                new_y  = 14'($urandom);
                colour = 6'($urandom);
            end
            @(negedge clk);
            if (k == 1 && exp_grant != 2'b00)
                check($sformatf("%s grant", tag), 32'(grant), 32'(exp_grant));
            if (k >= 112 && k <= 221 && plot) drawn++;
            check($sformatf("%s outputs N+%0d", tag, k), 32'(actual()), 32'(exp_q[k-1]));
        end
        if (exp_draw >= 0)
            check($sformatf("%s draw pixel count", tag), 32'(drawn), 32'(exp_draw));
    endtask

    initial begin
        vecs[0] = '{2'b11,  20,  20,  22,  21, 3'd3, 3'd1, 0, 0, 2'b01, 110};
        vecs[1] = '{2'b11,  40,  50,  41,  52, 3'd7, 3'd2, 0, 0, 2'b10, 110};
        vecs[2] = '{2'b11, 100,  10,  90,  12, 3'd1, 3'd4, 1, 0, 2'b01, 110};
        vecs[3] = '{2'b01,   0, 109,   1, 109, 3'd6, 3'd0, 1, 0, 2'b01, 110};
        vecs[4] = '{2'b10, 150, 110, 155, 115, 3'd2, 3'd0, 1, 0, 2'b10, 25};
        vecs[5] = '{2'b01,   5,   5,   6,   7, 3'd4, 3'd3, 5, 3, 2'b01, 110};
        vecs[6] = '{2'b10, 159, 119, 200,   0, 3'd5, 3'd1, 1, 0, 2'b10, 0};

        rst    = 1'b1;
        req    = 2'b11;
        old_x  = '0;
        old_y  = '0;
        new_x  = '0;
        new_y  = '0;
        colour = '0;
        bg     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset with req high", 32'(actual()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check("idle after reset release", 32'(actual()), 32'd0);
        model_last = 1;

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].ox, vecs[i].oy, vecs[i].nx,
                  vecs[i].ny, vecs[i].col, vecs[i].bg, vecs[i].drop_at, vecs[i].chg_at,
                  vecs[i].exp_grant, vecs[i].exp_draw);
        end

        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("rand%0d", i), 2'($urandom_range(1, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                  3'($urandom), 3'($urandom), int'($urandom_range(1, 200)),
                  int'($urandom_range(2, 220)), 2'b00, -1);
        end

        // Reset while the 41st draw pixel is on the outputs.
        req    = 2'b01;
        bg     = 3'd2;
        old_x  = {8'd0, 8'd30};
        old_y  = {7'd0, 7'd40};
        new_x  = {8'd0, 8'd50};
        new_y  = {7'd0, 7'd60};
        colour = {3'd0, 3'd5};
        @(posedge clk);
        #1;
        req = 2'b00;
        repeat (151) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid-draw pixel 40", 32'(actual()),
              32'(pack(2'b01, 2'b00, 1'b1, 1'b1, 8'd50, 7'd64, 3'd5)));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("outputs after mid-draw reset", 32'(actual()), 32'd0);
        model_last = 1;
        do_op("post-reset", 2'b10, 60, 30, 61, 31, 3'd3, 3'd0, 1, 0, 2'b10, 110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
